// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared definitions for the LED pattern sequencer.
//   mode_e          : display mode encoding (also driven on the `mode` port)
//   MODE_NEXT       : button-driven mode rotation COUNT->SCAN->BREATHE->BLINK->COUNT
//   DEF_* constants : default widths used when the top is instantiated bare
package led_seq_pkg;

  localparam int DEF_TICK_BITS = 32'd21;
  localparam int DEF_PWM_BITS  = 32'd4;
  localparam int DEF_N_LEDS    = 32'd8;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  function automatic mode_e MODE_NEXT(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_COUNT:   nxt = MODE_SCAN;
      MODE_SCAN:    nxt = MODE_BREATHE;
      MODE_BREATHE: nxt = MODE_BLINK;
      MODE_BLINK:   nxt = MODE_COUNT;
      default:      nxt = MODE_COUNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
// Free-running prescaler that paces every display pattern.
//   hwclk     : board clock
//   rst       : asynchronous active-high reset
//   pause     : holds the prescaler and suppresses the tick
//   clear     : synchronous restart of the prescaler (mode change)
//   tick      : combinational, high in the cycle the prescaler sits at all-ones
//   step_tick : registered copy of tick, one-cycle pulse per pattern step
module led_tick_gen
  import led_seq_pkg::*;
#(
  parameter int TICK_BITS = DEF_TICK_BITS
) (
  input  logic hwclk,
  input  logic rst,
  input  logic pause,
  input  logic clear,
  output logic tick,
  output logic step_tick
);

  localparam logic [TICK_BITS-1:0] PRESC_ONE = TICK_BITS'(32'd1);

  logic [TICK_BITS-1:0] presc_r;
  logic                 step_tick_r;

  // Tick is left combinational so the sequencer steps in the same edge that wraps the prescaler.
  assign tick      = (&presc_r) & ~pause;
  assign step_tick = step_tick_r;

  // Prescaler: cleared on mode change, frozen while paused, otherwise counts and wraps.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (clear) begin
      presc_r <= '0;
    end else if (!pause) begin
      presc_r <= presc_r + PRESC_ONE;
    end else begin
      presc_r <= presc_r;
    end
  end

  // Registered step pulse; a tick coinciding with a mode change is dropped.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      step_tick_r <= 1'b0;
    end else begin
      step_tick_r <= tick & ~clear;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer
// Pattern scheduler for the LED bank: four display modes stepped by a shared
// prescaler and rotated by a debounced push-button.
//   hwclk     : board clock, all state on the rising edge
//   rst       : asynchronous active-high reset
//   mode_btn  : debounced but unsynchronized button level
//   pause     : freezes prescaler and pattern state (breathe PWM keeps running)
//   leds      : registered LED drive, 1 = lit
//   mode      : current display mode (led_seq_pkg::mode_e encoding)
//   step_tick : registered one-cycle pulse per pattern step
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_BITS = DEF_TICK_BITS,
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int N_LEDS    = DEF_N_LEDS
) (
  input  logic              hwclk,
  input  logic              rst,
  input  logic              mode_btn,
  input  logic              pause,
  output logic [N_LEDS-1:0] leds,
  output logic [1:0]        mode,
  output logic              step_tick
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(32'd1);
  localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(N_LEDS - 32'd1);
  localparam logic [N_LEDS-1:0]   LED_ONE  = N_LEDS'(32'd1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(32'd1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  // Button path
  logic btn_sync1_r, btn_sync2_r, btn_prev_r;
  logic btn_valid1_r, btn_valid2_r, btn_armed_r;
  logic btn_rise_s;

  // Pacing
  logic tick_s, step_s;

  // Pattern state
  mode_e               mode_r;
  logic [N_LEDS-1:0]   step_cnt_r;
  logic [POS_W-1:0]    scan_pos_r;
  logic                scan_down_r;
  logic [PWM_BITS-1:0] duty_r;
  logic                duty_down_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                blink_r;
  logic [N_LEDS-1:0]   leds_next_s;
  logic [N_LEDS-1:0]   leds_r;

  // Two-flop synchronizer and edge detector for the button. The valid pipe marks
  // when btn_sync2_r holds a real pin sample; the button only arms after a real
  // low has been seen, so a press held through reset is ignored until re-pressed.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      btn_sync1_r  <= 1'b0;
      btn_sync2_r  <= 1'b0;
      btn_prev_r   <= 1'b0;
      btn_valid1_r <= 1'b0;
      btn_valid2_r <= 1'b0;
      btn_armed_r  <= 1'b0;
    end else begin
      btn_sync1_r  <= mode_btn;
      btn_sync2_r  <= btn_sync1_r;
      btn_prev_r   <= btn_sync2_r;
      btn_valid1_r <= 1'b1;
      btn_valid2_r <= btn_valid1_r;
      if (btn_valid2_r && !btn_sync2_r) begin
        btn_armed_r <= 1'b1;
      end else begin
        btn_armed_r <= btn_armed_r;
      end
    end
  end

  assign btn_rise_s = btn_sync2_r & ~btn_prev_r & btn_armed_r;

  // A mode change wins over a coincident tick; the pattern is not stepped.
  assign step_s = tick_s & ~btn_rise_s;

  led_tick_gen #(
    .TICK_BITS (TICK_BITS)
  ) u_tick_gen (
    .hwclk     (hwclk),
    .rst       (rst),
    .pause     (pause),
    .clear     (btn_rise_s),
    .tick      (tick_s),
    .step_tick (step_tick)
  );

  // Mode FSM and per-mode pattern state; a mode change restarts every pattern.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      mode_r      <= MODE_COUNT;
      step_cnt_r  <= '0;
      scan_pos_r  <= '0;
      scan_down_r <= 1'b0;
      duty_r      <= '0;
      duty_down_r <= 1'b0;
      pwm_cnt_r   <= '0;
      blink_r     <= 1'b0;
    end else if (btn_rise_s) begin
      mode_r      <= MODE_NEXT(mode_r);
      step_cnt_r  <= '0;
      scan_pos_r  <= '0;
      scan_down_r <= 1'b0;
      duty_r      <= '0;
      duty_down_r <= 1'b0;
      pwm_cnt_r   <= '0;
      blink_r     <= 1'b0;
    end else begin
      // PWM carrier runs through pause so a paused breathe keeps its glow.
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      if (step_s) begin
        case (mode_r)
          MODE_COUNT: begin
            step_cnt_r <= step_cnt_r + LED_ONE;
          end
          MODE_SCAN: begin
            // Turn around at the ends so each endpoint is shown for one step only.
            if (!scan_down_r) begin
              if (scan_pos_r == POS_MAX) begin
                scan_down_r <= 1'b1;
                scan_pos_r  <= POS_MAX - POS_ONE;
              end else begin
                scan_pos_r  <= scan_pos_r + POS_ONE;
              end
            end else begin
              if (scan_pos_r == '0) begin
                scan_down_r <= 1'b0;
                scan_pos_r  <= POS_ONE;
              end else begin
                scan_pos_r  <= scan_pos_r - POS_ONE;
              end
            end
          end
          MODE_BREATHE: begin
            if (!duty_down_r) begin
              if (duty_r == DUTY_MAX) begin
                duty_down_r <= 1'b1;
                duty_r      <= DUTY_MAX - PWM_ONE;
              end else begin
                duty_r      <= duty_r + PWM_ONE;
              end
            end else begin
              if (duty_r == '0) begin
                duty_down_r <= 1'b0;
                duty_r      <= PWM_ONE;
              end else begin
                duty_r      <= duty_r - PWM_ONE;
              end
            end
          end
          MODE_BLINK: begin
            blink_r <= ~blink_r;
          end
          default: begin
            blink_r <= blink_r;
          end
        endcase
      end else begin
        blink_r <= blink_r;
      end
    end
  end

  // LED image for the current pattern state.
  always_comb begin
    leds_next_s = '0;
    case (mode_r)
      MODE_COUNT:   leds_next_s = step_cnt_r;
      MODE_SCAN:    leds_next_s = LED_ONE << scan_pos_r;
      MODE_BREATHE: leds_next_s = (pwm_cnt_r < duty_r) ? '1 : '0;
      MODE_BLINK:   leds_next_s = blink_r ? '1 : '0;
      default:      leds_next_s = '0;
    endcase
  end

  // Output register: LEDs follow the pattern state one cycle later.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      leds_r <= '0;
    end else begin
      leds_r <= leds_next_s;
    end
  end

  assign leds = leds_r;
  assign mode = mode_r;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer
// Scoreboard bench for led_sequencer (TICK_BITS=3, PWM_BITS=2, N_LEDS=8).
// Stimulus pushes the expected result of each pattern step into exp_q; the
// monitor pops one entry per step_tick and checks leds/mode/step spacing.
module tb_led_sequencer;

  logic       hwclk;
  logic       rst;
  logic       mode_btn;
  logic       pause;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       step_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // kind 0: leds value one cycle after the step; kind 1: lit cycles out of 4 (breathe)
  typedef struct {
    bit         kind;
    logic [7:0] val;
    logic [1:0] md;
    int         gap;
  } exp_t;

  exp_t exp_q[$];

  led_sequencer #(
    .TICK_BITS (3),
    .PWM_BITS  (2),
    .N_LEDS    (8)
  ) dut (
    .hwclk     (hwclk),
    .rst       (rst),
    .mode_btn  (mode_btn),
    .pause     (pause),
    .leds      (leds),
    .mode      (mode),
    .step_tick (step_tick)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input bit kind, input logic [7:0] val, input logic [1:0] md, input int gap);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.md   = md;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      @(negedge hwclk);
      b++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_tick(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge hwclk);
      waited++;
    end while (step_tick !== 1'b1 && waited < budget);
    if (step_tick !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: no step_tick within %0d cycles", budget);
    end
  endtask

  // Button low long enough to re-arm, then a press; mode must flip exactly 3 edges later.
  task automatic press_btn(input logic [1:0] from, input logic [1:0] to);
    mode_btn = 1'b0;
    repeat (3) @(negedge hwclk);
    mode_btn = 1'b1;
    repeat (2) @(negedge hwclk);
    check("btn_latency_hold", 32'(mode), 32'(from));
    @(negedge hwclk);
    check("btn_mode_change", 32'(mode), 32'(to));
    mode_btn = 1'b0;
  endtask

  // Monitor: one scoreboard entry per presented step_tick.
  initial begin : monitor
    exp_t e;
    int   gap_now;
    int   last_tick;
    int   lit;
    int   dark;
    last_tick = 0;
    forever begin
      @(negedge hwclk);
      if (step_tick === 1'b1) begin
        gap_now   = cyc - last_tick;
        last_tick = cyc;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (e.gap != 0) check("step_gap", 32'(gap_now), 32'(e.gap));
          if (!e.kind) begin
            @(negedge hwclk);
            check("step_leds", 32'(leds), 32'(e.val));
            check("step_mode", 32'(mode), 32'(e.md));
          end else begin
            lit  = 0;
            dark = 0;
            repeat (4) begin
              @(negedge hwclk);
              if (leds === 8'hFF) lit++;
              else if (leds === 8'h00) dark++;
              else lit = lit + 100;
            end
            check("breathe_lit", 32'(lit), 32'(e.val));
            check("breathe_dark", 32'(dark), 32'd4 - 32'(e.val));
            check("breathe_mode", 32'(mode), 32'd2);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] scan_seq [15];
    logic [7:0] duty_seq [6];
    int n;
    int bad_tick;
    int bad_leds;
    int bad_mode;

    scan_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    duty_seq = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};

    rst      = 1'b1;
    mode_btn = 1'b0;
    pause    = 1'b0;
    @(negedge hwclk);
    check("reset_leds", 32'(leds), 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_step_tick", 32'(step_tick), 32'd0);
    @(negedge hwclk);
    rst = 1'b0;

    // COUNT: leds 1..4, one step every 8 cycles
    push_exp(1'b0, 8'h01, 2'd0, 0);
    for (int i = 2; i <= 4; i++) push_exp(1'b0, 8'(i), 2'd0, 8);
    repeat (3) @(negedge hwclk);
    check("count_start_dark", 32'(leds), 32'd0);
    check("count_mode", 32'(mode), 32'd0);
    wait_drain(60);

    // SCAN: full bounce with one-step endpoints
    press_btn(2'd0, 2'd1);
    push_exp(1'b0, scan_seq[0], 2'd1, 0);
    for (int i = 1; i < 15; i++) push_exp(1'b0, scan_seq[i], 2'd1, 8);
    @(negedge hwclk);
    check("scan_first_led", 32'(leds), 32'h01);
    wait_drain(150);

    // BREATHE: duty 0 dark, then 1,2,3,2,1,0 lit cycles per 4-cycle PWM period
    press_btn(2'd1, 2'd2);
    push_exp(1'b1, duty_seq[0], 2'd2, 0);
    for (int i = 1; i < 6; i++) push_exp(1'b1, duty_seq[i], 2'd2, 8);
    bad_leds = 0;
    repeat (6) begin
      @(negedge hwclk);
      if (leds !== 8'h00) bad_leds++;
    end
    check("breathe_duty0_dark", 32'(bad_leds), 32'd0);
    wait_drain(80);

    // BLINK with pause: prescaler is 3 when paused, so 8-3=5 cycles to the next step
    press_btn(2'd2, 2'd3);
    push_exp(1'b0, 8'hFF, 2'd3, 0);
    push_exp(1'b0, 8'h00, 2'd3, 8);
    @(negedge hwclk);
    check("blink_start_dark", 32'(leds), 32'd0);
    wait_tick(20, n);
    wait_tick(20, n);
    repeat (3) @(negedge hwclk);
    pause    = 1'b1;
    bad_tick = 0;
    bad_leds = 0;
    repeat (30) begin
      @(negedge hwclk);
      if (step_tick !== 1'b0) bad_tick++;
      if (leds !== 8'h00) bad_leds++;
    end
    check("pause_no_step_tick", 32'(bad_tick), 32'd0);
    check("pause_leds_held", 32'(bad_leds), 32'd0);
    push_exp(1'b0, 8'hFF, 2'd3, 0);
    pause = 1'b0;
    wait_tick(20, n);
    check("resume_delay", 32'(n), 32'd5);
    wait_drain(10);

    // COUNT, then a press whose btn_rise lands on the tick that would make step_cnt 6
    press_btn(2'd3, 2'd0);
    push_exp(1'b0, 8'h01, 2'd0, 0);
    for (int i = 2; i <= 5; i++) push_exp(1'b0, 8'(i), 2'd0, 8);
    repeat (5) wait_tick(20, n);
    repeat (5) @(negedge hwclk);
    mode_btn = 1'b1;
    repeat (3) @(negedge hwclk);
    check("collide_mode", 32'(mode), 32'd1);
    check("collide_tick_dropped", 32'(step_tick), 32'd0);
    check("collide_leds_hold", 32'(leds), 32'h05);
    mode_btn = 1'b0;
    // last step_tick was 8 cycles before the dropped one, next is 8 after: gap 16
    push_exp(1'b0, 8'h02, 2'd1, 16);
    push_exp(1'b0, 8'h04, 2'd1, 8);
    push_exp(1'b0, 8'h08, 2'd1, 8);
    push_exp(1'b0, 8'h10, 2'd1, 8);
    @(negedge hwclk);
    check("collide_scan_start", 32'(leds), 32'h01);
    wait_tick(20, n);
    check("collide_next_tick", 32'(n + 1), 32'd8);

    // Async reset mid-SCAN with the button held through reset
    repeat (3) wait_tick(20, n);
    @(negedge hwclk);
    check("scan_mid_leds", 32'(leds), 32'h10);
    mode_btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_leds", 32'(leds), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_step_tick", 32'(step_tick), 32'd0);
    repeat (3) @(negedge hwclk);
    rst      = 1'b0;
    bad_mode = 0;
    repeat (20) begin
      @(negedge hwclk);
      if (mode !== 2'd0) bad_mode++;
    end
    check("held_btn_ignored", 32'(bad_mode), 32'd0);
    press_btn(2'd0, 2'd1);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
